wbs_mem_arbiter: RTL and testbench

WBS_MEM_ARBITER -- requirements
Module: wbs_mem_arbiter

---
 rtl/wbs_mem_arbiter.sv | 111 +++++++++++
 tb/tb_wbs_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wbs_mem_arbiter.sv
// Arbitrates a single-port SRAM between a Wishbone host and an engine.
// The grant is combinational; the read-return owner is registered at issue.
module wbs_mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 55,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  arb_mode,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_lock,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  eng_req,
  input  logic                  eng_we,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  input  logic [DATA_WIDTH-1:0] eng_wdata,
  output logic                  eng_gnt,
  output logic                  eng_rvalid,
  output logic [DATA_WIDTH-1:0] eng_rdata,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    OWN_ENG  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  owner_e           last_owner;
  owner_e           rd_tag;
  logic             rd_pend;
  logic [CNT_W-1:0] starve_cnt;
  logic             lock_active;
  logic             lock_eff;
  logic             starved;
  logic             host_win;

  // Winner selection; a held lock drops out the moment host_lock or host_req falls.
  always_comb begin
    lock_eff = lock_active & host_lock & host_req;
    starved  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    host_win = host_req;
    if (host_req && eng_req) begin
      if (lock_eff)      host_win = 1'b1;
      else if (arb_mode) host_win = ~starved;
      else               host_win = (last_owner == OWN_ENG);
    end
  end

  assign host_gnt = ~wb_rst_i & host_win;
  assign eng_gnt  = ~wb_rst_i & eng_req & ~host_win;

  // SRAM port mux: idle values when nobody is granted.
  always_comb begin
    mem_csb0  = 1'b1;
    mem_web0  = 1'b1;
    mem_addr0 = '0;
    mem_din0  = '0;
    if (host_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = ~host_we;
      mem_addr0 = host_addr;
      mem_din0  = host_wdata;
    end else if (eng_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = ~eng_we;
      mem_addr0 = eng_addr;
      mem_din0  = eng_wdata;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_owner  <= OWN_ENG;
      starve_cnt  <= '0;
      lock_active <= 1'b0;
      rd_pend     <= 1'b0;
      rd_tag      <= OWN_ENG;
    end else begin
      if (host_gnt)     last_owner <= OWN_HOST;
      else if (eng_gnt) last_owner <= OWN_ENG;

      if (eng_gnt || !eng_req)        starve_cnt <= '0;
      else if (host_gnt && !starved)  starve_cnt <= starve_cnt + CNT_W'(1);

      if (host_gnt && host_lock)         lock_active <= 1'b1;
      else if (!host_lock || !host_req)  lock_active <= 1'b0;

      rd_pend <= (host_gnt & ~host_we) | (eng_gnt & ~eng_we);
      rd_tag  <= host_gnt ? OWN_HOST : OWN_ENG;
    end
  end

  // Read return lines up with the SRAM's one-cycle output; suppressed during reset.
  assign host_rvalid = ~wb_rst_i & rd_pend & (rd_tag == OWN_HOST);
  assign eng_rvalid  = ~wb_rst_i & rd_pend & (rd_tag == OWN_ENG);
  assign host_rdata  = host_rvalid ? mem_dout0 : '0;
  assign eng_rdata   = eng_rvalid  ? mem_dout0 : '0;

endmodule

// File: tb/tb_wbs_mem_arbiter.sv
// Directed bench for wbs_mem_arbiter: inputs change 1 unit after posedge,
// outputs are checked mid-cycle.
module tb_wbs_mem_arbiter;

  localparam int unsigned DW = 55;
  localparam int unsigned AW = 9;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          arb_mode;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          eng_req, eng_we;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata;
  logic          eng_gnt, eng_rvalid;
  logic [DW-1:0] eng_rdata;
  logic          mem_csb0, mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_din0;
  logic [DW-1:0] mem_dout0;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wbs_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .arb_mode(arb_mode),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid),
    .eng_rdata(eng_rdata), .mem_csb0(mem_csb0), .mem_web0(mem_web0),
    .mem_addr0(mem_addr0), .mem_din0(mem_din0), .mem_dout0(mem_dout0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic idle();
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
    eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = '0; mem_dout0 = '0;
  endtask

  logic [5:0]    rr_exp;
  logic [9:0]    pr_exp;
  logic          prev_host;
  logic [DW-1:0] pat;

  initial begin
    rr_exp = 6'b010101;
    pr_exp = 10'b0111101111;
    wb_rst_i = 1; arb_mode = 0;
    idle();
    // Reset with both requesting: nothing may be granted.
    host_req = 1; eng_req = 1;
    step(); mid();
    chk("rst_host_gnt", 64'(host_gnt), 64'd0);
    chk("rst_eng_gnt", 64'(eng_gnt), 64'd0);
    chk("rst_csb0", 64'(mem_csb0), 64'd1);
    chk("rst_web0", 64'(mem_web0), 64'd1);
    step();
    wb_rst_i = 0;

    // Round-robin alternating reads, returns in issue order with no bubble.
    prev_host = 0;
    for (int k = 0; k < 6; k++) begin
      host_req = 1; host_we = 0; host_addr = AW'(k);
      eng_req = 1;  eng_we = 0;  eng_addr = AW'(k + 32);
      pat = DW'(64'h100 + 64'(k));
      mem_dout0 = pat;
      mid();
      chk($sformatf("rr_host_gnt%0d", k), 64'(host_gnt), 64'(rr_exp[k]));
      chk($sformatf("rr_eng_gnt%0d", k), 64'(eng_gnt), 64'(!rr_exp[k]));
      chk($sformatf("rr_csb0_%0d", k), 64'(mem_csb0), 64'd0);
      if (k == 0) begin
        chk("rr_no_rvalid0", 64'({host_rvalid, eng_rvalid}), 64'd0);
      end else begin
        chk($sformatf("rr_hrv%0d", k), 64'(host_rvalid), 64'(prev_host));
        chk($sformatf("rr_erv%0d", k), 64'(eng_rvalid), 64'(!prev_host));
        chk($sformatf("rr_rdata%0d", k), 64'(prev_host ? host_rdata : eng_rdata), 64'(pat));
      end
      prev_host = rr_exp[k];
      step();
    end
    idle();
    mem_dout0 = DW'(64'h5A5A);
    mid();
    chk("rr_last_erv", 64'(eng_rvalid), 64'd1);
    chk("rr_last_erdata", 64'(eng_rdata), 64'h5A5A);
    chk("idle_csb0", 64'(mem_csb0), 64'd1);
    chk("idle_addr0", 64'(mem_addr0), 64'd0);
    step();

    // Lone host read at addr 1 and its one-cycle return.
    host_req = 1; host_we = 0; host_addr = 9'd1; mem_dout0 = '0;
    mid();
    chk("hrd_gnt", 64'(host_gnt), 64'd1);
    chk("hrd_csb0", 64'(mem_csb0), 64'd0);
    chk("hrd_web0", 64'(mem_web0), 64'd1);
    chk("hrd_addr0", 64'(mem_addr0), 64'd1);
    step();
    idle();
    mem_dout0 = 55'h00_1010_DEAD_BEEF;
    mid();
    chk("hrd_rvalid", 64'(host_rvalid), 64'd1);
    chk("hrd_rdata", 64'(host_rdata), 64'h00_1010_DEAD_BEEF);
    chk("hrd_no_erv", 64'(eng_rvalid), 64'd0);
    step();
    mid();
    chk("hrd_rvalid_off", 64'(host_rvalid), 64'd0);
    chk("hrd_rdata_zero", 64'(host_rdata), 64'd0);
    step();

    // Priority mode with starvation limit 4: H,H,H,H,E repeating.
    arb_mode = 1;
    for (int k = 0; k < 10; k++) begin
      host_req = 1; host_we = 1; host_addr = AW'(k);
      eng_req = 1;  eng_we = 1;  eng_addr = AW'(k + 64);
      mid();
      chk($sformatf("pr_host_gnt%0d", k), 64'(host_gnt), 64'(pr_exp[k]));
      chk($sformatf("pr_eng_gnt%0d", k), 64'(eng_gnt), 64'(!pr_exp[k]));
      step();
    end
    idle();

    // Locked host writes to addr 2 hold off the engine until host_lock falls.
    arb_mode = 0;
    host_req = 1; host_we = 1; host_addr = 9'd2; host_wdata = DW'(64'h0000_1111);
    host_lock = 1; eng_req = 1; eng_we = 1; eng_addr = 9'd9; eng_wdata = DW'(64'h77);
    mid();
    chk("lock_w1_hgnt", 64'(host_gnt), 64'd1);
    chk("lock_w1_din0", 64'(mem_din0), 64'h0000_1111);
    step();
    host_wdata = DW'(64'h2222_0000);
    mid();
    chk("lock_w2_hgnt", 64'(host_gnt), 64'd1);
    chk("lock_w2_egnt", 64'(eng_gnt), 64'd0);
    chk("lock_w2_web0", 64'(mem_web0), 64'd0);
    chk("lock_w2_din0", 64'(mem_din0), 64'h2222_0000);
    step();
    host_req = 0; host_lock = 0;
    mid();
    chk("lock_rel_egnt", 64'(eng_gnt), 64'd1);
    chk("lock_rel_addr0", 64'(mem_addr0), 64'd9);
    step();
    idle();

    // Lone engine write.
    eng_req = 1; eng_we = 1; eng_addr = 9'd5; eng_wdata = DW'(64'h1234);
    mid();
    chk("ewr_gnt", 64'(eng_gnt), 64'd1);
    chk("ewr_web0", 64'(mem_web0), 64'd0);
    chk("ewr_addr0", 64'(mem_addr0), 64'd5);
    chk("ewr_din0", 64'(mem_din0), 64'h1234);
    step();
    idle();
    mem_dout0 = DW'(64'hABCD);
    mid();
    chk("ewr_no_rvalid", 64'({host_rvalid, eng_rvalid}), 64'd0);
    step();

    // Engine read immediately followed by reset: its return is dropped.
    eng_req = 1; eng_we = 0; eng_addr = 9'd7;
    mid();
    chk("erd_gnt", 64'(eng_gnt), 64'd1);
    step();
    wb_rst_i = 1; host_req = 1; mem_dout0 = DW'(64'hFEED);
    mid();
    chk("rstrd_erv", 64'(eng_rvalid), 64'd0);
    chk("rstrd_erdata", 64'(eng_rdata), 64'd0);
    chk("rstrd_gnts", 64'({host_gnt, eng_gnt}), 64'd0);
    chk("rstrd_csb0", 64'(mem_csb0), 64'd1);
    step();
    wb_rst_i = 0;
    idle();
    mid();
    chk("post_rst_rv", 64'({host_rvalid, eng_rvalid}), 64'd0);
    chk("post_rst_din0", 64'(mem_din0), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
